// File: rtl/ex_mdu_if.sv
// ex_mdu_if: request/result handshake bundle between issue logic and the MDU stage
interface ex_mdu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [4:0]      in_rd_addr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd_addr;
  modport master (
    output in_valid, in_op, in_a, in_b, in_rd_addr, out_ready,
    input  in_ready, out_valid, out_result, out_rd_addr
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd_addr, out_ready,
    output in_ready, out_valid, out_result, out_rd_addr
  );
endinterface

// File: rtl/ex_mdu_stage.sv
// ex_mdu_stage: iterative RV32M multiply/divide unit retiring STEP_BITS bits per cycle
module ex_mdu_stage #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ex_mdu_if.slave          bus,
  output logic             busy,
  output logic [4:0]       ex_fwd_rs_addr,
  output logic [XLEN-1:0]  ex_fwd_rs_data
);
  localparam int ITERS = XLEN / STEP_BITS;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic              neg, byp;
  logic [XLEN-1:0]   hi, lo, opb, res;
  logic [XLEN-1:0]   hi_n, lo_n, mag_a, mag_b, byp_val, q_s, r_s, res_c;
  logic [XLEN:0]     t;
  logic [2*XLEN-1:0] prod_s;
  logic              ge, a_sgn, b_sgn, div0, ovf, neg_in;
  assign bus.in_ready    = state == IDLE;
  assign bus.out_valid   = state == DONE;
  assign bus.out_result  = res;
  assign bus.out_rd_addr = rd;
  assign busy            = state != IDLE;
  assign ex_fwd_rs_addr  = bus.out_valid ? rd : '0;
  assign ex_fwd_rs_data  = bus.out_valid ? res : '0;
  assign a_sgn   = (bus.in_op == 3'd1 || bus.in_op == 3'd2 || bus.in_op == 3'd4 || bus.in_op == 3'd6) & bus.in_a[XLEN-1];
  assign b_sgn   = (bus.in_op == 3'd1 || bus.in_op == 3'd4 || bus.in_op == 3'd6) & bus.in_b[XLEN-1];
  assign mag_a   = a_sgn ? -bus.in_a : bus.in_a;
  assign mag_b   = b_sgn ? -bus.in_b : bus.in_b;
  assign div0    = bus.in_op[2] && bus.in_b == '0;
  assign ovf     = bus.in_op[2] && !bus.in_op[0] && bus.in_a == {1'b1, {(XLEN-1){1'b0}}} && bus.in_b == '1;
  assign byp_val = div0 ? (bus.in_op[1] ? bus.in_a : '1) : (bus.in_op[1] ? '0 : bus.in_a);
  // remainder sign follows the dividend; everything else takes the xor of operand signs
  assign neg_in  = (bus.in_op[2] & bus.in_op[1]) ? a_sgn : a_sgn ^ b_sgn;
  // hi/lo hold accumulator/multiplier for MUL* and remainder/quotient-dividend for DIV*
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    t    = '0;
    ge   = 1'b0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (op[2]) begin
        t    = {hi_n, lo_n[XLEN-1]};
        ge   = t >= {1'b0, opb};
        t    = ge ? t - {1'b0, opb} : t;
        hi_n = t[XLEN-1:0];
        lo_n = {lo_n[XLEN-2:0], ge};
      end else begin
        t = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opb} : '0);
        {hi_n, lo_n} = {t, lo_n[XLEN-1:1]};
      end
    end
  end
  assign prod_s = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
  assign q_s    = neg ? -lo_n : lo_n;
  assign r_s    = neg ? -hi_n : hi_n;
  assign res_c  = byp ? lo : !op[2] ? (op[1:0] == 2'd0 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]) : op[1] ? r_s : q_s;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      rd    <= '0;
      neg   <= 1'b0;
      byp   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      res   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        state <= CALC;
        cnt   <= (div0 || ovf) ? '0 : CW'(ITERS - 1);
        op    <= bus.in_op;
        rd    <= bus.in_rd_addr;
        neg   <= neg_in;
        byp   <= div0 || ovf;
        hi    <= '0;
        opb   <= bus.in_op[2] ? mag_b : mag_a;
        lo    <= (div0 || ovf) ? byp_val : bus.in_op[2] ? mag_a : mag_b;
      end
      if (state == CALC) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt == '0 ? '0 : cnt - 1'b1;
        if (cnt == '0) begin
          state <= DONE;
          res   <= res_c;
        end
      end
      if (state == DONE && bus.out_ready) state <= IDLE;
    end
  end
endmodule

// File: doc/ex_mdu_stage.md
EX_MDU_STAGE -- requirements
Module: ex_mdu_stage

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; SHALL be even and >= 8.
REQ-002 Parameter STEP_BITS, default 1: quotient/multiplier bits retired per cycle; SHALL divide XLEN evenly.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-006 Port in_op, input, 3: RV32M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-007 Ports in_a, in_b (input, XLEN each): rs1 and rs2 operands.
REQ-008 Port in_rd_addr, input, 5: destination register.
REQ-009 Port flush, input, 1: synchronous kill of in-flight work.
REQ-010 Ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-011 Ports out_result (output, XLEN) and out_rd_addr (output, 5): result and its destination.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.
REQ-013 Ports ex_fwd_rs_addr (output, 5) and ex_fwd_rs_data (output, XLEN): forwarding tap.

Function
REQ-014 States SHALL be IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept occurs on a rising edge with in_valid=1, in_ready=1 and flush=0; op, operands and rd_addr SHALL be latched there.
REQ-016 Normal accept SHALL go IDLE->CALC with iteration counter = XLEN/STEP_BITS-1.
REQ-017 Each CALC edge SHALL retire STEP_BITS iterations and decrement the counter; the edge at counter 0 SHALL enter DONE.
REQ-018 Latency SHALL be XLEN/STEP_BITS cycles: out_valid rises on edge T+XLEN/STEP_BITS for accept edge T (32 for the defaults).
REQ-019 Signed ops SHALL run on operand magnitudes; result sign SHALL be corrected in the final CALC edge.
REQ-020 MUL SHALL return product bits [XLEN-1:0]; MULH/MULHSU/MULHU SHALL return bits [2*XLEN-1:XLEN] with s*s, s*u and u*u signedness.
REQ-021 Division SHALL truncate toward zero; REM sign SHALL follow the dividend.
REQ-022 Divide by zero SHALL skip CALC and enter DONE on edge T+1: DIV/DIVU = all ones; REM/REMU = in_a.
REQ-023 DIV overflow (in_a = -2^(XLEN-1), in_b = -1) SHALL skip CALC and enter DONE on edge T+1: DIV = in_a; REM = 0.
REQ-024 In DONE, out_valid=1; out_result and out_rd_addr SHALL stay stable until out_ready=1, then return to IDLE on that edge.
REQ-025 No new request SHALL be accepted on the DONE->IDLE edge; the earliest next accept is one cycle later.
REQ-026 flush=1 SHALL force IDLE on the next edge from any state, with out_valid=0, and SHALL override a same-cycle accept.
REQ-027 flush=1 in DONE with out_ready=1 SHALL count as flushed: no handshake is recorded.
REQ-028 ex_fwd_rs_addr SHALL equal out_rd_addr when out_valid=1, else 0; ex_fwd_rs_data SHALL equal out_result when out_valid=1, else 0.
REQ-029 in_rd_addr=0 SHALL execute normally; the forwarding address is then 0.
REQ-030 Outputs SHALL depend only on registered state; there SHALL be no combinational in->out paths except in_ready/out_valid from state.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, counter 0, out_valid=0, busy=0, in_ready=1, out_result=0, out_rd_addr=0 and forwarding outputs 0, regardless of clk.
REQ-032 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow reset release.

Verification (XLEN=32, STEP_BITS=1 unless noted)
REQ-033 MUL 7 x 0xFFFFFFFD, rd=5 -> out_valid at cycle 32, result 0xFFFFFFEB, ex_fwd_rs_addr=5; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; STEP_BITS=4 -> out_valid at cycle 8.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF after 1 cycle; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 cycle; REM of the same -> 0.
REQ-036 out_ready held low 5 cycles in DONE -> out_valid, out_result and forwarding outputs stable all 5 cycles; in_ready=0 until the cycle after out_ready=1.
REQ-037 flush at cycle 10 of a DIV, with in_valid=1 the same cycle -> no accept, IDLE next cycle, out_valid never asserted; a following MUL 3 x 4 -> 12.
REQ-038 rst pulsed low mid-CALC between clock edges -> outputs 0 and in_ready=1 immediately, no stale result after release.
